// File: rtl/noc_pkg.sv
// Shared types for the lookahead router: flow-control mode, flit preamble, arbiter state.
package noc;

  typedef enum logic {
    StopVoid = 1'b0,
    Credit   = 1'b1
  } flow_control_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set req bit at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NumW = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] pos;
  logic [IW:0]   sum;

  // Rotate so that ptr lands on bit 0; the lowest set bit is then the winner offset.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
  end

  assign any    = |req;
  assign sum    = {1'b0, ptr} + {1'b0, pos};
  assign idx    = (sum >= NumW) ? IW'(sum - NumW) : IW'(sum);
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/lookahead_output_arbiter.sv
// Per-output-port scheduler: round-robin among inputs, packet lock head-to-tail,
// transfers gated by stop-based or credit-based downstream flow control.
module lookahead_output_arbiter
  import noc::*;
#(
  parameter int unsigned FlowControl = 0,
  parameter int unsigned NumInputs   = 4,
  parameter int unsigned Depth       = 4,
  localparam int unsigned IW = $clog2(NumInputs),
  localparam int unsigned CW = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NumInputs-1:0] req,
  input  logic [NumInputs-1:0] tail,
  input  logic                 stop_in,
  input  logic                 credit_in,
  output logic [NumInputs-1:0] grant,
  output logic                 data_void_out,
  output logic                 locked,
  output logic [IW-1:0]        owner,
  output logic [CW-1:0]        credits
);

  localparam flow_control_t Fc        = flow_control_t'(FlowControl);
  localparam bit            UseCredit = (Fc == Credit);
  localparam logic [CW-1:0] CredMax   = CW'(Depth);
  localparam logic [CW-1:0] CredRst   = UseCredit ? CredMax : '0;

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cred_q, cred_d;
  logic [NumInputs-1:0] grant_c;
  logic [NumInputs-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 can_send;
  logic                 xfer;
  logic [NumInputs-1:0] own_oh;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] x);
    return (x == IW'(NumInputs - 1)) ? '0 : x + IW'(1);
  endfunction

  rr_pick #(.N(NumInputs), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign can_send = UseCredit ? (cred_q != '0) : ~stop_in;
  assign own_oh   = NumInputs'(1) << owner_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_c = '0;
    case (state_q)
      IDLE: begin
        if (pick_any && can_send) begin
          grant_c = pick_oh;
          owner_d = pick_idx;
          if (|(tail & pick_oh)) rr_d = next_ptr(pick_idx);
          else                   state_d = LOCKED;
        end
      end
      LOCKED: begin
        if ((|(req & own_oh)) && can_send) begin
          grant_c = own_oh;
          if (|(tail & own_oh)) begin
            state_d = IDLE;
            rr_d    = next_ptr(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is forced low while reset is asserted, even with requests pending.
  assign grant         = rst ? grant_c : '0;
  assign xfer          = |grant;
  assign data_void_out = ~xfer;
  assign locked        = (state_q == LOCKED);
  assign owner         = owner_q;
  assign credits       = cred_q;

  always_comb begin
    cred_d = cred_q;
    if (UseCredit) begin
      if (xfer && !credit_in)                         cred_d = cred_q - CW'(1);
      else if (!xfer && credit_in && cred_q != CredMax) cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cred_q  <= CredRst;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cred_q  <= cred_d;
    end
  end

  // A returned credit with the counter already full means upstream lost track of slots.
  always @(posedge clk) begin
    if (rst && UseCredit && credit_in && !xfer) begin
      credit_ovf: assert (cred_q != CredMax)
        else $warning("credit_in received with counter already at Depth");
    end
  end

endmodule

// File: tb/tb_lookahead_output_arbiter.sv
// Directed bench: stop-flow instance (a) for RR/lock/stop, credit instance (b, Depth=2) for credits.
module tb_lookahead_output_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_a = '0, tail_a = '0, req_b = '0, tail_b = '0;
  logic       stop_a = 1'b0, credit_b = 1'b0;
  logic [3:0] grant_a, grant_b;
  logic       void_a, void_b, locked_a, locked_b;
  logic [1:0] owner_a, owner_b, credits_a, credits_b;
  logic       credit_a_unused = 1'b0, stop_b_unused = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lookahead_output_arbiter #(.FlowControl(0), .NumInputs(4), .Depth(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .tail(tail_a), .stop_in(stop_a),
    .credit_in(credit_a_unused), .grant(grant_a), .data_void_out(void_a),
    .locked(locked_a), .owner(owner_a), .credits(credits_a)
  );

  lookahead_output_arbiter #(.FlowControl(1), .NumInputs(4), .Depth(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .tail(tail_b), .stop_in(stop_b_unused),
    .credit_in(credit_b), .grant(grant_b), .data_void_out(void_b),
    .locked(locked_b), .owner(owner_b), .credits(credits_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the edge; combinational checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [4];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;

    // Reset with all inputs requesting
    req_a = 4'b1111; tail_a = 4'b1111;
    #12;
    chk("rst_grant_a", 32'(grant_a), 32'h0);
    chk("rst_void_a", 32'(void_a), 32'h1);
    chk("rst_locked_a", 32'(locked_a), 32'h0);
    chk("rst_owner_a", 32'(owner_a), 32'h0);
    chk("rst_credits_a", 32'(credits_a), 32'h0);
    chk("rst_credits_b", 32'(credits_b), 32'h2);
    chk("rst_void_b", 32'(void_b), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_grant_a", 32'(grant_a), 32'h1);

    // Round-robin over 8 single-flit packets
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_grant_%0d", i), 32'(grant_a), 32'(rr_exp[i % 4]));
      chk($sformatf("rr_void_%0d", i), 32'(void_a), 32'h0);
      tick();
      #1;
    end
    chk("rr_owner_wrap", 32'(owner_a), 32'h3);

    // Move rr pointer to 1, then lock on input 2 with input 0 also requesting
    req_a = 4'b0001; tail_a = 4'b0001; #1;
    chk("pre_lock_grant", 32'(grant_a), 32'h1);
    tick();
    req_a = 4'b0101; tail_a = 4'b0000; #1;
    chk("lock_head", 32'(grant_a), 32'h4);
    tick(); #1;
    chk("lock_locked", 32'(locked_a), 32'h1);
    chk("lock_owner", 32'(owner_a), 32'h2);
    chk("lock_body", 32'(grant_a), 32'h4);
    tick();
    req_a = 4'b0001; #1;
    chk("lock_bubble_grant", 32'(grant_a), 32'h0);
    chk("lock_bubble_void", 32'(void_a), 32'h1);
    chk("lock_bubble_locked", 32'(locked_a), 32'h1);
    tick();
    req_a = 4'b0101; tail_a = 4'b0100; #1;
    chk("lock_tail", 32'(grant_a), 32'h4);
    tick();
    req_a = 4'b1001; tail_a = 4'b1001; #1;
    chk("unlock_locked", 32'(locked_a), 32'h0);
    chk("post_lock_rr3", 32'(grant_a), 32'h8);
    tick(); #1;
    chk("post_lock_rr0", 32'(grant_a), 32'h1);
    tick();

    // Stop during a locked packet on input 1
    req_a = 4'b0010; tail_a = 4'b0000; #1;
    chk("stop_head", 32'(grant_a), 32'h2);
    tick();
    stop_a = 1'b1; #1;
    chk("stop_grant", 32'(grant_a), 32'h0);
    chk("stop_void", 32'(void_a), 32'h1);
    tick(); #1;
    chk("stop_held_locked", 32'(locked_a), 32'h1);
    chk("stop_held_owner", 32'(owner_a), 32'h1);
    stop_a = 1'b0; tail_a = 4'b0010; #1;
    chk("stop_resume", 32'(grant_a), 32'h2);
    tick(); #1;
    chk("stop_unlocked", 32'(locked_a), 32'h0);
    req_a = 4'b1111; tail_a = 4'b1111; stop_a = 1'b1; #1;
    chk("stop_idle_grant", 32'(grant_a), 32'h0);
    tick();
    stop_a = 1'b0; req_a = 4'b0000; tail_a = 4'b0000;

    // Credits: three single-flit packets with only two credits
    req_b = 4'b0001; tail_b = 4'b0001; #1;
    chk("cred_g1", 32'(grant_b), 32'h1);
    tick(); #1;
    chk("cred_after1", 32'(credits_b), 32'h1);
    chk("cred_g2", 32'(grant_b), 32'h1);
    tick(); #1;
    chk("cred_empty", 32'(credits_b), 32'h0);
    chk("cred_stall", 32'(grant_b), 32'h0);
    chk("cred_stall_void", 32'(void_b), 32'h1);
    credit_b = 1'b1; #1;
    chk("cred_pulse_stall", 32'(grant_b), 32'h0);
    tick();
    credit_b = 1'b0; #1;
    chk("cred_one", 32'(credits_b), 32'h1);
    chk("cred_g3", 32'(grant_b), 32'h1);
    tick(); #1;
    chk("cred_zero_again", 32'(credits_b), 32'h0);

    // Simultaneous transfer + credit, then overflow at Depth
    req_b = 4'b0000; credit_b = 1'b1;
    tick(); #1;
    chk("cred_ret", 32'(credits_b), 32'h1);
    req_b = 4'b0001; #1;
    chk("cred_both_grant", 32'(grant_b), 32'h1);
    tick(); #1;
    chk("cred_both_same", 32'(credits_b), 32'h1);
    req_b = 4'b0000;
    tick(); #1;
    chk("cred_full", 32'(credits_b), 32'h2);
    tick(); #1;
    chk("cred_saturate", 32'(credits_b), 32'h2);
    credit_b = 1'b0; tail_b = 4'b0000;

    // Reset mid-packet drops the lock
    req_a = 4'b0100; tail_a = 4'b0000; #1;
    chk("mid_head", 32'(grant_a), 32'h4);
    tick(); #1;
    chk("mid_locked", 32'(locked_a), 32'h1);
    rst = 1'b0; #1;
    chk("mid_rst_locked", 32'(locked_a), 32'h0);
    chk("mid_rst_grant", 32'(grant_a), 32'h0);
    chk("mid_rst_owner", 32'(owner_a), 32'h0);
    tick();
    rst = 1'b1; req_a = 4'b0010; tail_a = 4'b0010; #1;
    chk("mid_rel_grant", 32'(grant_a), 32'h2);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
